// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the oversampling UART receiver.
//   UART_OVERSAMPLE : default oversample ticks per bit period
//   UART_DATA_BITS  : default data bits per frame
//   rxState_t       : receiver FSM state encoding
// Optional feature macro: UART_RX_PARITY_EN adds the ST_PARITY state.
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   // ST_PARITY only exists when the parity bit is part of the frame.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
      ST_WAIT_HIGH = 3'd4,
      ST_PARITY    = 3'd5
`else
      ST_WAIT_HIGH = 3'd4
`endif
   } rxState_t;

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for a single asynchronous level.
//   clock   : system clock
//   reset   : synchronous, active-high; both flops load RESET_VALUE
//   i_async : asynchronous input
//   o_sync  : synchronised output, two cycles behind i_async
// ---------------------------------------------------------------------------
module uart_rx_sync #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // The first flop may go metastable; the second gives it a full cycle
   // to settle before anything downstream looks at the value.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_oversampler.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampler
// Oversampling UART receiver driven by the divided baud clock.
//   clock        : system clock, rising edge
//   reset        : synchronous, active-high
//   tick_clock   : divided clock; each rising edge is one oversample tick
//   rx           : asynchronous serial line, idle high
//   data_out     : received byte, stable while valid
//   valid        : holding register full
//   ready        : consumer takes the byte when valid && ready
//   frame_error  : one-cycle pulse, stop bit sampled low
//   overrun      : one-cycle pulse, finished byte dropped (holding full)
//   parity_error : one-cycle pulse, only with UART_RX_PARITY_EN
// Optional feature macro: UART_RX_PARITY_EN turns 8N1 framing into 8E1.
// ---------------------------------------------------------------------------
module uart_rx_oversampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 tick_clock,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ready,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_error,
`endif
   output logic                 frame_error,
   output logic                 overrun
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic                 r_tickQ;
   logic                 w_tick;
   logic                 w_rxS;
   rxState_t             r_state;
   logic [CW-1:0]        r_cnt;
   logic [IW-1:0]        r_bitIdx;
   logic [DATA_BITS-1:0] r_shift;
`ifdef UART_RX_PARITY_EN
   logic                 r_parErr;
`endif

   // The divided clock is only a level here; remembering last cycle's value
   // turns its rising edge into a single-cycle tick in our own domain.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tickQ <= 1'b0;
      end else begin
         r_tickQ <= tick_clock;
      end
   end

   assign w_tick = tick_clock & ~r_tickQ;

   uart_rx_sync #(
      .RESET_VALUE (1'b1)
   ) uRxSync (
      .clock   (clock),
      .reset   (reset),
      .i_async (rx),
      .o_sync  (w_rxS)
   );

   // Receiver FSM plus the holding register and the status pulses.
   // Pulses default low every cycle so they last exactly one cycle. The
   // consumer-side clear of valid is written first so a same-cycle load
   // further down overrides it and the register stays full.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bitIdx    <= '0;
         r_shift     <= '0;
         data_out    <= '0;
         valid       <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parErr     <= 1'b0;
         parity_error <= 1'b0;
`endif
      end else begin
         frame_error <= 1'b0;
         overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error <= 1'b0;
`endif
         if (valid && ready) begin
            valid <= 1'b0;
         end

         if (w_tick) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_rxS) begin
                     r_state <= ST_START;
                     r_cnt   <= '0;
                  end
               end

               // Re-check the line half a bit in; a short low is a glitch.
               ST_START: begin
                  if (r_cnt == CNT_HALF) begin
                     if (w_rxS) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_state  <= ST_DATA;
                        r_cnt    <= '0;
                        r_bitIdx <= '0;
`ifdef UART_RX_PARITY_EN
                        r_parErr <= 1'b0;
`endif
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               // Bits arrive LSB first, so shifting right from the MSB
               // leaves the byte LSB-aligned after the last bit.
               ST_DATA: begin
                  if (r_cnt == CNT_LAST) begin
                     r_shift  <= {w_rxS, r_shift[DATA_BITS-1:1]};
                     r_cnt    <= '0;
                     r_bitIdx <= r_bitIdx + 1'b1;
                     if (r_bitIdx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_STOP;
`endif
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

`ifdef UART_RX_PARITY_EN
               // Even parity: the parity bit equals the XOR of the data.
               ST_PARITY: begin
                  if (r_cnt == CNT_LAST) begin
                     r_parErr <= w_rxS ^ (^r_shift);
                     r_cnt    <= '0;
                     r_state  <= ST_STOP;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
`endif

               // A low stop bit discards the byte; otherwise it is offered
               // to the holding register, which only accepts it if it is
               // empty or being emptied in this same cycle.
               ST_STOP: begin
                  if (r_cnt == CNT_LAST) begin
                     r_cnt <= '0;
                     if (!w_rxS) begin
                        frame_error <= 1'b1;
                        r_state     <= ST_WAIT_HIGH;
                     end else begin
                        r_state <= ST_IDLE;
                        if (!valid || ready) begin
                           data_out <= r_shift;
                           valid    <= 1'b1;
                        end else begin
                           overrun <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_error <= r_parErr;
`endif
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               // A held-low line (break) must go high before the next start.
               ST_WAIT_HIGH: begin
                  if (w_rxS) begin
                     r_state <= ST_IDLE;
                  end
               end

               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_oversampler
// Directed and randomised frames for uart_rx_oversampler with OVERSAMPLE=4
// and tick_clock toggling every 2 system clocks (one bit = 16 clocks).
// Build with UART_RX_PARITY_EN defined to include the 8E1 parity case.
// ---------------------------------------------------------------------------
module tb_uart_rx_oversampler;

   localparam int OS       = 4;
   localparam int DB       = 8;
   localparam int BIT_CLKS = OS * 4;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clock     = 1'b0;
   logic          reset     = 1'b1;
   logic          tickClock = 1'b0;
   logic          rx        = 1'b1;
   logic          ready     = 1'b1;
   logic [DB-1:0] dataOut;
   logic          valid;
   logic          frameError;
   logic          overrun;
   logic          peSig;

   int total = 0;
   int bad   = 0;

   // What the monitor saw
   logic [7:0] rxQ[$];
   int         feCount   = 0;
   int         ovCount   = 0;
   int         peCount   = 0;
   int         runLen    = 0;
   int         lastRun   = 0;
   logic       prevValid = 1'b0;
   logic       peAtRise  = 1'b0;

   // Frame-level reference model
   logic [7:0] expQ[$];
   int         expFe     = 0;
   int         expOv     = 0;
   int         expPe     = 0;
   bit         modelHold = 1'b0;

   uart_rx_oversampler #(
      .OVERSAMPLE (OS),
      .DATA_BITS  (DB)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .tick_clock   (tickClock),
      .rx           (rx),
      .data_out     (dataOut),
      .valid        (valid),
      .ready        (ready),
`ifdef UART_RX_PARITY_EN
      .parity_error (peSig),
`endif
      .frame_error  (frameError),
      .overrun      (overrun)
   );

`ifndef UART_RX_PARITY_EN
   assign peSig = 1'b0;
`endif

   // System clock
   always #5 clock = ~clock;

   // Divided baud clock: toggles every 2 system clocks
   initial begin
      forever begin
         repeat (2) @(negedge clock);
         tickClock = ~tickClock;
      end
   end

   // Monitor: records each delivered byte (valid rising), counts pulses
   // and measures how long valid stays high.
   always @(negedge clock) begin
      if (valid && !prevValid) begin
         rxQ.push_back(dataOut);
         peAtRise <= peSig;
      end
      if (frameError) feCount <= feCount + 1;
      if (overrun)    ovCount <= ovCount + 1;
      if (peSig)      peCount <= peCount + 1;
      if (valid) begin
         runLen <= runLen + 1;
      end else begin
         if (prevValid) lastRun <= runLen;
         runLen <= 0;
      end
      prevValid <= valid;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic settle();
      @(negedge clock);
      #1;
   endtask

   task automatic driveBit(input logic b);
      rx = b;
      waitClocks(BIT_CLKS);
   endtask

   // Sends one frame and updates the reference model with the outcome
   // that the frame rules dictate for the current ready level.
   task automatic applyStimulus(input logic [7:0] d, input logic stopVal, input logic badPar);
      driveBit(1'b0);
      for (int i = 0; i < DB; i++) driveBit(d[i]);
      if (PAR_EN) driveBit((^d) ^ badPar);
      driveBit(stopVal);
      if (!stopVal) begin
         expFe++;
      end else if (!modelHold || ready) begin
         expQ.push_back(d);
         modelHold = !ready;
         if (PAR_EN && badPar) expPe++;
      end else begin
         expOv++;
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".count"}, rxQ.size(), expQ.size());
      for (int i = 0; i < expQ.size(); i++) begin
         if (i < rxQ.size()) checkOutput({tag, ".byte"}, rxQ[i], expQ[i]);
      end
      checkOutput({tag, ".frameErr"}, feCount, expFe);
      checkOutput({tag, ".overrun"}, ovCount, expOv);
      checkOutput({tag, ".parityErr"}, peCount, expPe);
   endtask

   initial begin
      $display("[TB] start, OVERSAMPLE=%0d parity=%0d", OS, PAR_EN);

      // Reset state
      waitClocks(3);
      #1;
      checkOutput("rst.valid", valid, 1'b0);
      checkOutput("rst.dataOut", dataOut, 8'h00);
      checkOutput("rst.frameErr", frameError, 1'b0);
      checkOutput("rst.overrun", overrun, 1'b0);
      reset = 1'b0;
      waitClocks(BIT_CLKS * 2);

      // 0xA5 with ready held high
      applyStimulus(8'hA5, 1'b1, 1'b0);
      waitClocks(BIT_CLKS);
      settle();
      checkModel("a5");
      checkOutput("a5.dataOut", dataOut, 8'hA5);
      checkOutput("a5.validWidth", lastRun, 1);
      checkOutput("a5.validNow", valid, 1'b0);

      // One-tick low glitch on idle line
      rx = 1'b0;
      waitClocks(4);
      rx = 1'b1;
      waitClocks(BIT_CLKS * 3);
      settle();
      checkModel("glitch");
      checkOutput("glitch.valid", valid, 1'b0);

      // 0x3C with low stop bit, then a 3-bit-time break
      applyStimulus(8'h3C, 1'b0, 1'b0);
      waitClocks(BIT_CLKS * 3);
      settle();
      checkModel("break");
      checkOutput("break.valid", valid, 1'b0);
      rx = 1'b1;
      waitClocks(BIT_CLKS * 2);
      settle();
      checkModel("breakEnd");

      // Overrun: 0x11 then 0x22 with ready low
      ready = 1'b0;
      applyStimulus(8'h11, 1'b1, 1'b0);
      waitClocks(BIT_CLKS / 2);
      applyStimulus(8'h22, 1'b1, 1'b0);
      waitClocks(BIT_CLKS);
      settle();
      checkModel("ovr");
      checkOutput("ovr.valid", valid, 1'b1);
      checkOutput("ovr.dataOut", dataOut, 8'h11);
      ready = 1'b1;
      modelHold = 1'b0;
      settle();
      checkOutput("ovr.released", valid, 1'b0);
      checkOutput("ovr.dataHeld", dataOut, 8'h11);

      // Reset after bit 3 of 0xFF, then 0x5A
      driveBit(1'b0);
      for (int i = 0; i < 4; i++) driveBit(1'b1);
      reset = 1'b1;
      waitClocks(2);
      reset = 1'b0;
      settle();
      checkOutput("midRst.dataOut", dataOut, 8'h00);
      checkOutput("midRst.valid", valid, 1'b0);
      waitClocks(BIT_CLKS * 8);
      applyStimulus(8'h5A, 1'b1, 1'b0);
      waitClocks(BIT_CLKS);
      settle();
      checkModel("midRst");
      checkOutput("midRst.last", dataOut, 8'h5A);

`ifdef UART_RX_PARITY_EN
      // 0x07 with parity bit 0 (even parity requires 1)
      applyStimulus(8'h07, 1'b1, 1'b1);
      waitClocks(BIT_CLKS);
      settle();
      checkModel("par");
      checkOutput("par.dataOut", dataOut, 8'h07);
      checkOutput("par.atValidRise", peAtRise, 1'b1);
`endif

      // Random bytes, random idle gaps (including back-to-back)
      for (int n = 0; n < 10; n++) begin
         applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0);
         waitClocks($urandom_range(0, 12));
      end
      waitClocks(BIT_CLKS);
      settle();
      checkModel("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
